// File: rtl/clusterv_main_sram_arbiter.sv
// Round-robin arbiter sharing the cluster main SRAM port among N_REQ requesters.
// Grants are combinational; read data is steered back via a one-hot owner register.
module clusterv_main_sram_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W/8-1:0]  req_byte_en,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic [ADDR_W-1:0]          t_addr,
  output logic                       t_read_en,
  output logic                       t_write_en,
  output logic [DATA_W/8-1:0]        t_byte_en,
  output logic [DATA_W-1:0]          t_write_data,
  input  logic [DATA_W-1:0]          t_read_data
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] rd_owner_q, rd_owner_d;
  logic [IDX_W-1:0] win;
  logic             hit;

  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] base,
    input int               k
  );
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // Pick the first requester at or after rr_ptr, wrapping; no grant in reset.
  always_comb begin
    gnt = '0;
    win = '0;
    hit = 1'b0;
    if (!reset) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!hit && req[wrap_add(rr_ptr_q, k)]) begin
          hit = 1'b1;
          win = wrap_add(rr_ptr_q, k);
        end
      end
      if (hit) gnt[win] = 1'b1;
    end
  end

  // Drive the SRAM port from the winner's slice; idle port is all zero.
  always_comb begin
    t_addr       = '0;
    t_byte_en    = '0;
    t_write_data = '0;
    t_read_en    = 1'b0;
    t_write_en   = 1'b0;
    if (hit) begin
      t_addr       = req_addr[int'(win)*ADDR_W +: ADDR_W];
      t_byte_en    = req_byte_en[int'(win)*BE_W +: BE_W];
      t_write_data = req_wdata[int'(win)*DATA_W +: DATA_W];
      t_write_en   = req_we[win];
      t_read_en    = ~req_we[win];
    end
  end

  // Next pointer follows the winner; read owner tracks this cycle's read.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rd_owner_d = '0;
    if (hit) rr_ptr_d = wrap_add(win, 1);
    if (t_read_en) rd_owner_d = gnt;
  end

  // Pointer and read-owner state; reset drops any read in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      rd_owner_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign rvalid = rd_owner_q;
  assign rdata  = t_read_data;

endmodule
